regfile_wb_arbiter: RTL

Write-back arbiter and pending-write scoreboard for the processor's 32-entry register file. It shares the register file's single write port among NREQ result producers, such as the ALU and the load unit, through a valid/ready handshake. The granted write is driven onto the port from a registered stage. It also tracks destination registers that have been reserved at issue and not yet written, and raises a stall for dependent instructions. It sits between the execute/memory stages and the register file write port.

---
 rtl/regfile_arb_pkg.sv | 25 ++
 rtl/rr_arbiter.sv | 55 +++++
 rtl/regfile_wb_arbiter.sv | 91 +++++++++
 3 files changed

// File: rtl/regfile_arb_pkg.sv
// Shared defaults and types for the register-file write-back arbiter.
// Configuration macro: WB_ARB_RR_EN selects round-robin grant (fixed priority otherwise).
package regfile_arb_pkg;

    localparam int unsigned AW_DEF = 5;
    localparam int unsigned DW_DEF = 32;
    localparam int unsigned NREG   = 2 ** AW_DEF;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_e;

`ifdef WB_ARB_RR_EN
    localparam arb_mode_e ARB_MODE = ARB_RR;
`else
    localparam arb_mode_e ARB_MODE = ARB_FIXED;
`endif

    typedef struct packed {
        logic [AW_DEF-1:0] rd;
        logic [DW_DEF-1:0] data;
    } wb_bundle_t;

endpackage

// File: rtl/rr_arbiter.sv
// One-hot grant generator for the write-back port.
// WB_ARB_RR_EN defined: round-robin with last-grant pointer; undefined: lowest index wins.
module rr_arbiter #(
    parameter int unsigned NREQ = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] valid,
    input  logic            accept,
    output logic [NREQ-1:0] grant
);

`ifdef WB_ARB_RR_EN
    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [IW-1:0] last_grant;
    logic [IW-1:0] grant_idx;

    // Search starts one past the last granted index and wraps.
    always_comb begin
        logic [IW-1:0] idx;
        logic          found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int unsigned off = 1; off <= NREQ; off++) begin
            idx = IW'((int unsigned'(last_grant) + off) % NREQ);
            if (!found && valid[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = idx;
                found      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= IW'(NREQ - 1);
        end else if (accept) begin
            last_grant <= grant_idx;
        end
    end
`else
    logic unused_fixed;

    // Isolate the lowest set bit of valid.
    always_comb begin
        grant = valid & (~valid + NREQ'(1));
    end

    assign unused_fixed = ^{clk, rst_n, accept};
`endif

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-back arbiter with registered output stage and pending-write scoreboard.
// Grant policy follows WB_ARB_RR_EN (see rr_arbiter).
module regfile_wb_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    parameter int unsigned AW   = AW_DEF,
    parameter int unsigned DW   = DW_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*AW-1:0]   req_rd,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic                 rf_reg_write,
    output logic [AW-1:0]        rf_rd,
    output logic [DW-1:0]        rf_write_data,
    input  logic                 rsv_valid,
    input  logic [AW-1:0]        rsv_rd,
    input  logic [AW-1:0]        chk_rs,
    input  logic [AW-1:0]        chk_rt,
    output logic                 stall,
    output logic [(2**AW)-1:0]   busy
);

    logic [NREQ-1:0]    grant;
    logic               transfer;
    logic [AW-1:0]      sel_rd;
    logic [DW-1:0]      sel_data;
    logic [(2**AW)-1:0] busy_nxt;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .valid  (req_valid),
        .accept (transfer),
        .grant  (grant)
    );

    assign req_ready = rst_n ? grant : '0;
    assign transfer  = |(req_valid & req_ready);

    // One-hot grant lets the selection be a plain AND-OR mux.
    always_comb begin
        sel_rd   = '0;
        sel_data = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            sel_rd   = sel_rd   | (req_rd[i*AW +: AW]   & {AW{req_ready[i]}});
            sel_data = sel_data | (req_data[i*DW +: DW] & {DW{req_ready[i]}});
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_reg_write  <= 1'b0;
            rf_rd         <= '0;
            rf_write_data <= '0;
        end else begin
            rf_reg_write <= transfer;
            if (transfer) begin
                rf_rd         <= sel_rd;
                rf_write_data <= sel_data;
            end
        end
    end

    // Set is applied after clear so a same-cycle reservation wins.
    always_comb begin
        busy_nxt = busy;
        if (rf_reg_write) begin
            busy_nxt[rf_rd] = 1'b0;
        end
        if (rsv_valid) begin
            busy_nxt[rsv_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    assign stall = busy[chk_rs] | busy[chk_rt];

endmodule
